sprite_rotator: RTL and testbench
=================================

# sprite_rotator

Parametrised sprite rotation engine. It holds a list of up to MAX_PTS lit sprite pixels, rotates each one about the sprite centre through a pipelined CORDIC rotator, and writes the results into an IMG_H x IMG_W one-bit bitmap. A display or game-logic reader accesses that bitmap row by row. The block sits between game logic (which loads points and issues start/theta) and the VGA/sprite compositor (which reads rows).

## Interface
Parameters:
- IMG_W, 48, bitmap width in pixels (also sprite width)
- IMG_H, 48, bitmap height in rows
- MAX_PTS, 64, point-list depth
- ANGLE_W, 13, angle width, signed Q2.10 radians
- FRAC, 4, fractional bits carried on the CORDIC x/y datapath
- CORDIC_LAT, 19, CORDIC pipeline latency in cycles

Ports:
- CLOCK_50  in  1  sole clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- theta  in  ANGLE_W  rotation angle; latched on accepted start
- num_pts  in  clog2(MAX_PTS+1)  number of points to process; latched on start
- pt_we  in  1  point-list write strobe; ignored while busy
- pt_addr  in  clog2(MAX_PTS)  point-list write address
- pt_x, pt_y  in  clog2(IMG_W), clog2(IMG_H)  unsigned pixel coordinate to store
- rd_row  in  clog2(IMG_H)  bitmap row select
- rd_data  out  IMG_W  row bitmap; bit i = column i; combinational from rd_row
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of run

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE -> CLEAR on start. CLEAR zeroes one row per cycle, rows 0..IMG_H-1.
- CLEAR -> FEED. FEED issues point k (k = 0..num_pts-1) into the CORDIC, one per cycle. If num_pts = 0, the block skips FEED and goes straight to DRAIN.
- FEED -> DRAIN. DRAIN lasts CORDIC_LAT cycles, then moves to DONE. DONE lasts one cycle, then returns to IDLE.
- Input conversion: xr = (pt_x − IMG_W/2) << FRAC, yr = (pt_y − IMG_H/2) << FRAC, both signed, width clog2(IMG_W)+FRAC+2.
- Rotation: x' = xr·cosθ − yr·sinθ, y' = xr·sinθ + yr·cosθ. The core compensates CORDIC gain.
- Output conversion: round to nearest, ties toward +inf: p = (v + 2^(FRAC−1)) >>> FRAC, then add the centre back.
- Clipping: a result with px<0, px≥IMG_W, py<0 or py≥IMG_H is discarded; it is not written.
- Write: a valid in-range result sets bitmap[py][px] = 1 (OR-write). Duplicate hits are harmless.
- Validity tracking: a CORDIC_LAT-deep valid shift register runs beside the CORDIC. Only issued points produce writes, so no pipe-flush garbage reaches the bitmap.
- Point list and bitmap are not cleared by reset. Bitmap content is undefined until the first completed CLEAR.
- start while busy: ignored. pt_we while busy: ignored; the list is stable for the whole run.
- Reset mid-run: the FSM goes to IDLE and the valid pipe clears to 0. Bitmap is left partial; no done pulse.

## Timing
- Reset values: busy=0, done=0, FSM=IDLE, all counters 0, valid pipe 0. rd_data reflects memory.
- For a start accepted at cycle 0, done pulses at cycle 1 + IMG_H + num_pts + CORDIC_LAT (default, 10 points: cycle 78).
- busy falls on the same edge that done rises.
- The last bitmap write lands no later than the cycle before done. A rd_data read in the done cycle sees the final image.
- rd_data during busy shows partial content; it is legal to read but meaningless.

## Configuration
- SPRITE_ROT_CLIP_CNT_EN defined:
  - adds output port clip_cnt (clog2(MAX_PTS+1) bits), reset 0;
  - it clears on accepted start and increments once per discarded out-of-range result;
  - it holds after done.
- Undefined: port absent, no counter logic.

## Structure
- Package sprite_rot_pkg holds:
  - FSM state enum;
  - centre constants derived from IMG_W/IMG_H;
  - a function for the round-and-recentre step;
  - width localparams.
- Sub-module cordic_rot_pipe wraps the vendor CORDIC core with a fixed latency CORDIC_LAT. It has ports clk, areset (driven from ~resetn), a, x, y, xo, yo.
- A bit-true behavioural model of cordic_rot_pipe is provided for simulation.
- Point list, bitmap, FSM and valid pipe live in sprite_rotator.

## Test plan
- Reset mid-run:
  - stimulus: assert resetn=0 during FEED, release, then start again with the same list;
  - response: no done in between, busy=0 after reset, and the second run's image matches a clean run.
- Identity:
  - stimulus: θ=0, points (0,0),(47,47),(24,24), start;
  - response: done at cycle 1+48+3+19=71, exactly those three bits set.
- Quarter turn:
  - stimulus: θ=13'b0_01_1001001000 (π/2), point (25,24);
  - response: only rd_row=25 bit 24 set; point (24,30) lands at (18,24).
- Clipping:
  - stimulus: θ=π/4 (13'b0_00_1100100100), point (47,47) (rel 23,23 → 0,32.5);
  - response: no write; with SPRITE_ROT_CLIP_CNT_EN, clip_cnt=1.
- Empty list:
  - stimulus: num_pts=0, start;
  - response: done at cycle 68, bitmap all zero.
- Busy guard:
  - stimulus: during a run, pulse start and pt_we (addr 0 → (5,5));
  - response: the run is unaffected, no second done, and point 0 is unchanged on the next run.

Source files
------------

// File: rtl/sprite_rot_pkg.sv
// sprite_rot_pkg: shared types, constants and helpers for the sprite rotator.
//   - state_e         : control FSM encoding
//   - PI_Q/HALF_PI_Q  : angle constants in Q2.10 radians
//   - K_GAIN_Q        : reciprocal CORDIC gain, K_GAIN_FRAC fractional bits
//   - centre_of()     : sprite centre along one axis
//   - xy_width()      : signed width of the CORDIC x/y datapath
//   - round_recentre(): round-to-nearest (ties to +inf) and add centre back
package sprite_rot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int PI_Q        = 3217;  // pi   * 1024
  localparam int HALF_PI_Q   = 1608;  // pi/2 * 1024
  localparam int K_GAIN_Q    = 622;   // 1/1.64676 * 1024
  localparam int K_GAIN_FRAC = 10;

  function automatic int centre_of(input int dim);
    return dim / 2;
  endfunction

  // Two guard bits: one for sign, one for rotation growth up to sqrt(2).
  function automatic int xy_width(input int img_w, input int frac);
    return $clog2(img_w) + frac + 2;
  endfunction

  function automatic logic signed [31:0] round_recentre(input logic signed [31:0] v,
                                                        input int frac,
                                                        input int centre);
    logic signed [31:0] half;
    half = 32'sd1 <<< (frac - 1);
    return ((v + half) >>> frac) + 32'(centre);
  endfunction

endpackage

// File: rtl/sprite_rotator_cordic.sv
// cordic_rot_pipe: bit-true behavioural model of the vendor CORDIC rotator,
// fixed latency LAT cycles, gain compensated.
//   clk    : clock
//   areset : asynchronous active-high reset of the delay line
//   a      : signed Q2.10 rotation angle
//   x, y   : signed input vector
//   xo, yo : signed rotated vector, valid LAT cycles after the inputs
module cordic_rot_pipe
  import sprite_rot_pkg::*;
#(
  parameter int ANGLE_W = 13,
  parameter int XY_W    = 12,
  parameter int LAT     = 19
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic signed [ANGLE_W-1:0] a,
  input  logic signed [XY_W-1:0]    x,
  input  logic signed [XY_W-1:0]    y,
  output logic signed [XY_W-1:0]    xo,
  output logic signed [XY_W-1:0]    yo
);

  localparam int G     = 6;            // extra fractional guard bits
  localparam int IW    = XY_W + G + 2;
  localparam int ZW    = ANGLE_W + 2;
  localparam int PW    = IW + 12;
  localparam int ITERS = 11;

  function automatic logic signed [ZW-1:0] atan_q(input int i);
    case (i)
      0:       return ZW'(804);
      1:       return ZW'(475);
      2:       return ZW'(251);
      3:       return ZW'(127);
      4:       return ZW'(64);
      5:       return ZW'(32);
      6:       return ZW'(16);
      7:       return ZW'(8);
      8:       return ZW'(4);
      9:       return ZW'(2);
      10:      return ZW'(1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [2*XY_W-1:0] rotate(input logic signed [ANGLE_W-1:0] ang,
                                               input logic signed [XY_W-1:0]    xin,
                                               input logic signed [XY_W-1:0]    yin);
    logic signed [ZW-1:0] z;
    logic signed [IW-1:0] xs, ys, xn, yn;
    logic signed [PW-1:0] prod;
    z  = ZW'(ang);
    xs = IW'(xin) <<< G;
    ys = IW'(yin) <<< G;
    // Fold angles beyond +-pi/2 by a half turn so the iterations converge.
    if (z > ZW'(HALF_PI_Q)) begin
      z  = z - ZW'(PI_Q);
      xs = -xs;
      ys = -ys;
    end else if (z < -ZW'(HALF_PI_Q)) begin
      z  = z + ZW'(PI_Q);
      xs = -xs;
      ys = -ys;
    end
    // Pre-scale by 1/K so the micro-rotations end at unit gain.
    prod = PW'(xs) * PW'(K_GAIN_Q);
    xs   = IW'((prod + PW'(1 << (K_GAIN_FRAC - 1))) >>> K_GAIN_FRAC);
    prod = PW'(ys) * PW'(K_GAIN_Q);
    ys   = IW'((prod + PW'(1 << (K_GAIN_FRAC - 1))) >>> K_GAIN_FRAC);
    for (int i = 0; i < ITERS; i++) begin
      if (z[ZW-1] == 1'b0) begin
        xn = xs - (ys >>> i);
        yn = ys + (xs >>> i);
        z  = z - atan_q(i);
      end else begin
        xn = xs + (ys >>> i);
        yn = ys - (xs >>> i);
        z  = z + atan_q(i);
      end
      xs = xn;
      ys = yn;
    end
    xs = (xs + IW'(1 << (G - 1))) >>> G;
    ys = (ys + IW'(1 << (G - 1))) >>> G;
    return {XY_W'(xs), XY_W'(ys)};
  endfunction

  logic [2*XY_W-1:0] pipe_q [LAT];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= rotate(a, x, y);
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {xo, yo} = pipe_q[LAT-1];

endmodule

// File: rtl/sprite_rotator.sv
// sprite_rotator: rotates a list of lit sprite pixels about the sprite centre
// and renders them into an IMG_H x IMG_W one-bit bitmap.
//   CLOCK_50/resetn : clock, asynchronous active-low reset
//   start/theta/num_pts : run request, angle (Q2.10) and point count
//   pt_we/pt_addr/pt_x/pt_y : point-list write port (ignored while busy)
//   rd_row/rd_data  : combinational bitmap row read
//   busy/done       : run in progress / one-cycle end-of-run pulse
//   clip_cnt        : discarded out-of-range results (only with
//                     SPRITE_ROT_CLIP_CNT_EN defined)
module sprite_rotator
  import sprite_rot_pkg::*;
#(
  parameter int IMG_W      = 48,
  parameter int IMG_H      = 48,
  parameter int MAX_PTS    = 64,
  parameter int ANGLE_W    = 13,
  parameter int FRAC       = 4,
  parameter int CORDIC_LAT = 19
) (
  input  logic                           CLOCK_50,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [ANGLE_W-1:0]             theta,
  input  logic [$clog2(MAX_PTS+1)-1:0]   num_pts,
  input  logic                           pt_we,
  input  logic [$clog2(MAX_PTS)-1:0]     pt_addr,
  input  logic [$clog2(IMG_W)-1:0]       pt_x,
  input  logic [$clog2(IMG_H)-1:0]       pt_y,
  input  logic [$clog2(IMG_H)-1:0]       rd_row,
  output logic [IMG_W-1:0]               rd_data,
  output logic                           busy,
  output logic                           done
`ifdef SPRITE_ROT_CLIP_CNT_EN
  ,
  output logic [$clog2(MAX_PTS+1)-1:0]   clip_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_PTS + 1);
  localparam int AW    = $clog2(MAX_PTS);
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int DW    = $clog2(CORDIC_LAT + 1);
  localparam int XY_W  = xy_width(IMG_W, FRAC);
  localparam int CX    = centre_of(IMG_W);
  localparam int CY    = centre_of(IMG_H);

  state_e                   state_q, state_d;
  logic [YW-1:0]            row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]         feed_cnt_q, feed_cnt_d;
  logic [DW-1:0]            drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]         num_pts_q, num_pts_d;
  logic [ANGLE_W-1:0]       theta_q, theta_d;
  logic [CORDIC_LAT-1:0]    vld_q, vld_d;
  logic [XW-1:0]            pt_x_q [MAX_PTS];
  logic [YW-1:0]            pt_y_q [MAX_PTS];
  logic [IMG_W-1:0]         bitmap_q [IMG_H];
  logic                     start_acc, issue, clr_we, pt_wr;
  logic                     last_row, last_feed, last_drain;
  logic signed [XY_W-1:0]   xr, yr, rx, ry;
  logic signed [31:0]       px, py;
  logic                     in_range, wr_hit;

  assign last_row   = (row_cnt_q == YW'(IMG_H - 1));
  assign last_feed  = ((feed_cnt_q + CNT_W'(1)) == num_pts_q);
  assign last_drain = (drain_cnt_q == DW'(CORDIC_LAT - 1));
  assign pt_wr      = pt_we & ~busy;

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: if (last_row) state_d = (num_pts_q == '0) ? ST_DRAIN : ST_FEED;
      ST_FEED:  if (last_feed) state_d = ST_DRAIN;
      ST_DRAIN: if (last_drain) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    issue     = 1'b0;
    clr_we    = 1'b0;
    start_acc = 1'b0;
    unique case (state_q)
      ST_IDLE:  start_acc = start;
      ST_CLEAR: begin busy = 1'b1; clr_we = 1'b1; end
      ST_FEED:  begin busy = 1'b1; issue  = 1'b1; end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    row_cnt_d   = (clr_we && !last_row) ? row_cnt_q + 1'b1 : '0;
    feed_cnt_d  = (issue && !last_feed) ? feed_cnt_q + 1'b1 : '0;
    drain_cnt_d = (state_q == ST_DRAIN && !last_drain) ? drain_cnt_q + 1'b1 : '0;
    num_pts_d   = start_acc ? num_pts : num_pts_q;
    theta_d     = start_acc ? theta : theta_q;
    // The valid pipe tracks the CORDIC exactly; only issued points emerge valid.
    vld_d       = CORDIC_LAT'({vld_q, issue});
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      row_cnt_q   <= '0;
      feed_cnt_q  <= '0;
      drain_cnt_q <= '0;
      num_pts_q   <= '0;
      vld_q       <= '0;
    end else begin
      row_cnt_q   <= row_cnt_d;
      feed_cnt_q  <= feed_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      num_pts_q   <= num_pts_d;
      vld_q       <= vld_d;
    end
  end

  always_ff @(posedge CLOCK_50) theta_q <= theta_d;

  always_ff @(posedge CLOCK_50) begin
    if (pt_wr) begin
      pt_x_q[pt_addr] <= pt_x;
      pt_y_q[pt_addr] <= pt_y;
    end
  end

  // Centre-relative fixed-point coordinates of the point being issued
  always_comb begin
    xr = (XY_W'(pt_x_q[feed_cnt_q[AW-1:0]]) - XY_W'(CX)) <<< FRAC;
    yr = (XY_W'(pt_y_q[feed_cnt_q[AW-1:0]]) - XY_W'(CY)) <<< FRAC;
  end

  cordic_rot_pipe #(
    .ANGLE_W (ANGLE_W),
    .XY_W    (XY_W),
    .LAT     (CORDIC_LAT)
  ) u_cordic (
    .clk    (CLOCK_50),
    .areset (~resetn),
    .a      (theta_q),
    .x      (xr),
    .y      (yr),
    .xo     (rx),
    .yo     (ry)
  );

  always_comb begin
    px       = round_recentre(32'(rx), FRAC, CX);
    py       = round_recentre(32'(ry), FRAC, CY);
    in_range = (px >= 0) && (px < IMG_W) && (py >= 0) && (py < IMG_H);
    wr_hit   = vld_q[CORDIC_LAT-1] && in_range;
  end

  // The pipe is always empty during CLEAR, so clear and hit never collide.
  always_ff @(posedge CLOCK_50) begin
    if (clr_we)      bitmap_q[row_cnt_q] <= '0;
    else if (wr_hit) bitmap_q[py[YW-1:0]][px[XW-1:0]] <= 1'b1;
  end

  assign rd_data = bitmap_q[rd_row];

`ifdef SPRITE_ROT_CLIP_CNT_EN
  logic [CNT_W-1:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (start_acc)                                clip_cnt_d = '0;
    else if (vld_q[CORDIC_LAT-1] && !in_range)    clip_cnt_d = clip_cnt_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) clip_cnt_q <= '0;
    else         clip_cnt_q <= clip_cnt_d;
  end

  assign clip_cnt = clip_cnt_q;
`endif

endmodule

// File: tb/tb_sprite_rotator.sv
module tb_sprite_rotator;

  localparam int IMG_W = 48, IMG_H = 48, MAX_PTS = 64, ANGLE_W = 13, FRAC = 4, LAT = 19;

  logic              CLOCK_50 = 1'b0;
  logic              resetn = 1'b0, start = 1'b0, pt_we = 1'b0;
  logic [ANGLE_W-1:0] theta = '0;
  logic [6:0]        num_pts = '0;
  logic [5:0]        pt_addr = '0, pt_x = '0, pt_y = '0, rd_row = '0;
  logic [IMG_W-1:0]  rd_data;
  logic              busy, done;
`ifdef SPRITE_ROT_CLIP_CNT_EN
  logic [6:0]        clip_cnt;
`endif

  sprite_rotator dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (start),
    .theta    (theta),
    .num_pts  (num_pts),
    .pt_we    (pt_we),
    .pt_addr  (pt_addr),
    .pt_x     (pt_x),
    .pt_y     (pt_y),
    .rd_row   (rd_row),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done)
`ifdef SPRITE_ROT_CLIP_CNT_EN
    ,
    .clip_cnt (clip_cnt)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int bx [MAX_PTS];
  int by [MAX_PTS];
  int               exp_lat_q  [$];
  logic [IMG_W-1:0] exp_row_q  [$];
  int               exp_clip_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load_pt(input int a, input int x, input int y);
    @(negedge CLOCK_50);
    pt_we = 1'b1; pt_addr = 6'(a); pt_x = 6'(x); pt_y = 6'(y);
    @(negedge CLOCK_50);
    pt_we = 1'b0;
    bx[a] = x;
    by[a] = y;
  endtask

  // Reference image from real-valued rotation of the bench's own point list.
  task automatic push_expect(input logic [ANGLE_W-1:0] th, input int n);
    logic [IMG_W-1:0] img [IMG_H];
    real ang, c, s, xr, yr;
    int px, py, clips;
    clips = 0;
    ang = $itor($signed(th)) / 1024.0;
    c = $cos(ang);
    s = $sin(ang);
    for (int r = 0; r < IMG_H; r++) img[r] = '0;
    for (int k = 0; k < n; k++) begin
      xr = $itor((bx[k] - IMG_W / 2) * (1 << FRAC));
      yr = $itor((by[k] - IMG_H / 2) * (1 << FRAC));
      px = $rtoi($floor((xr * c - yr * s + 8.0) / 16.0)) + IMG_W / 2;
      py = $rtoi($floor((xr * s + yr * c + 8.0) / 16.0)) + IMG_H / 2;
      if (px >= 0 && px < IMG_W && py >= 0 && py < IMG_H) img[py][px] = 1'b1;
      else clips++;
    end
    exp_lat_q.push_back(1 + IMG_H + n + LAT);
    for (int r = 0; r < IMG_H; r++) exp_row_q.push_back(img[r]);
    exp_clip_q.push_back(clips);
  endtask

  task automatic kick(input logic [ANGLE_W-1:0] th, input int n, input bit expect_done,
                      output int s);
    @(negedge CLOCK_50);
    theta = th; num_pts = 7'(n); start = 1'b1;
    s = cyc;
    if (expect_done) push_expect(th, n);
    @(negedge CLOCK_50);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic finish_run(input int s);
    int t, lat;
    t = 0;
    while (done !== 1'b1 && t < 400) begin
      @(negedge CLOCK_50);
      t++;
    end
    lat = (done === 1'b1) ? cyc - s : -1;
    check("done_latency", 64'(lat), 64'(exp_lat_q.pop_front()));
    check("busy_low_at_done", 64'(busy), 64'd0);
    @(negedge CLOCK_50);
    check("done_one_cycle", 64'(done), 64'd0);
    for (int r = 0; r < IMG_H; r++) begin
      rd_row = 6'(r);
      #1;
      check($sformatf("row%0d", r), 64'(rd_data), 64'(exp_row_q.pop_front()));
    end
`ifdef SPRITE_ROT_CLIP_CNT_EN
    check("clip_cnt", 64'(clip_cnt), 64'(exp_clip_q.pop_front()));
`endif
  endtask

  task automatic run(input logic [ANGLE_W-1:0] th, input int n);
    int s;
    kick(th, n, 1'b1, s);
    finish_run(s);
  endtask

  task automatic no_done(input int ncyc, input string tag);
    int cnt;
    cnt = 0;
    repeat (ncyc) begin
      @(negedge CLOCK_50);
      if (done === 1'b1) cnt++;
    end
    check(tag, 64'(cnt), 64'd0);
  endtask

  initial begin
    int s;
    repeat (3) @(negedge CLOCK_50);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
`ifdef SPRITE_ROT_CLIP_CNT_EN
    check("reset_clip_cnt", 64'(clip_cnt), 64'd0);
`endif
    resetn = 1'b1;

    // Identity
    load_pt(0, 0, 0);
    load_pt(1, 47, 47);
    load_pt(2, 24, 24);
    run(13'd0, 3);

    // Quarter turn
    load_pt(0, 25, 24);
    load_pt(1, 24, 30);
    run(13'd1608, 2);

    // Clipping at pi/4
    load_pt(0, 47, 47);
    run(13'd804, 1);

    // Empty list
    run(13'd0, 0);

    // Half turn, negative quarter turn, 0.5 rad
    load_pt(0, 30, 20);
    load_pt(1, 25, 24);
    run(13'd3217, 2);
    run(13'(-1608), 2);
    load_pt(0, 34, 24);
    load_pt(1, 24, 14);
    load_pt(2, 40, 30);
    run(13'd512, 3);

    // Reset during FEED, then a clean rerun of the same list
    kick(13'd512, 3, 1'b0, s);
    repeat (49) @(negedge CLOCK_50);
    resetn = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    no_done(80, "midreset_no_done");
    run(13'd512, 3);

    // Start and point writes during a run are ignored
    load_pt(0, 10, 12);
    kick(13'd0, 1, 1'b1, s);
    repeat (10) @(negedge CLOCK_50);
    start = 1'b1; pt_we = 1'b1; pt_addr = 6'd0; pt_x = 6'd5; pt_y = 6'd5;
    @(negedge CLOCK_50);
    start = 1'b0; pt_we = 1'b0;
    finish_run(s);
    no_done(100, "guard_no_second_done");
    run(13'd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
